// File: rtl/commit_unit.sv
// Retire stage: writes up to two GPR destinations through one shared write port,
// then updates EIP/EFLAGS. A commit takes three cycles: accept, WR0, WR1.
module commit_unit #(
    parameter logic [31:0] RESET_EIP    = 32'h0000_0000,
    parameter logic [31:0] RESET_ESP    = 32'h0000_0000,
    parameter logic [31:0] RESET_EFLAGS = 32'h0000_0002
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  opnd0_w,
    input  logic [31:0]  opnd1_w,
    input  logic [31:0]  o_eflags,
    input  logic [31:0]  next_eip,
    input  logic [1:0]   dest0_kind,
    input  logic [1:0]   dest1_kind,
    input  logic [2:0]   dest0_sel,
    input  logic [2:0]   dest1_sel,
    input  logic [1:0]   dest0_width,
    input  logic [1:0]   dest1_width,
    output logic [255:0] gprs,
    output logic [31:0]  eflags_q,
    output logic [31:0]  eip_q,
    output logic         commit_done
);
    typedef enum logic [1:0] {IDLE, WR0, WR1} state_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [2:0]  sel;
        logic [1:0]  width;
        logic [31:0] data;
    } dest_t;

    localparam logic [1:0]  KIND_GPR = 2'b01;
    localparam logic [31:0] EFL_SET  = 32'h0000_0002;
    localparam logic [31:0] EFL_CLR  = 32'h0000_8028;

    state_t           state;
    dest_t            hold0;
    dest_t            hold1;
    logic [31:0]      hold_eip;
    logic [31:0]      hold_efl;
    logic [7:0][31:0] regs;

    dest_t       wd;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [31:0] wr_old;
    logic [31:0] wr_val;

    // Shared write port: merge the new bytes into the current register value.
    // 8-bit selects 4-7 address the high byte of the low word of GPR sel-4.
    always_comb begin
        wd     = (state == WR1) ? hold1 : hold0;
        wr_en  = ((state == WR0) || (state == WR1)) && (wd.kind == KIND_GPR);
        wr_idx = (wd.width == 2'b00) ? {1'b0, wd.sel[1:0]} : wd.sel;
        wr_old = regs[wr_idx];
        case (wd.width)
            2'b00:   wr_val = wd.sel[2] ? {wr_old[31:16], wd.data[7:0], wr_old[7:0]}
                                        : {wr_old[31:8], wd.data[7:0]};
            2'b01:   wr_val = {wr_old[31:16], wd.data[15:0]};
            default: wr_val = wd.data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold0       <= '0;
            hold1       <= '0;
            hold_eip    <= '0;
            hold_efl    <= '0;
            regs        <= '0;
            regs[4]     <= RESET_ESP;
            eip_q       <= RESET_EIP;
            eflags_q    <= RESET_EFLAGS | EFL_SET;
            commit_done <= 1'b0;
        end else begin
            commit_done <= 1'b0;
            if (wr_en)
                regs[wr_idx] <= wr_val;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hold0    <= '{kind: dest0_kind, sel: dest0_sel, width: dest0_width, data: opnd0_w};
                        hold1    <= '{kind: dest1_kind, sel: dest1_sel, width: dest1_width, data: opnd1_w};
                        hold_eip <= next_eip;
                        hold_efl <= o_eflags;
                        state    <= WR0;
                    end
                end
                WR0: state <= WR1;
                WR1: begin
                    eip_q       <= hold_eip;
                    eflags_q    <= (hold_efl | EFL_SET) & ~EFL_CLR;
                    commit_done <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign gprs     = regs;

endmodule

// File: tb/tb_commit_unit.sv
// Bench for commit_unit: reference register model feeding a scoreboard queue,
// a vector table of commits, and hand sequences for latency, back-to-back and reset abort.
module tb_commit_unit;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  opnd0_w, opnd1_w, o_eflags, next_eip;
    logic [1:0]   dest0_kind, dest1_kind;
    logic [2:0]   dest0_sel, dest1_sel;
    logic [1:0]   dest0_width, dest1_width;
    logic [255:0] gprs;
    logic [31:0]  eflags_q, eip_q;
    logic         commit_done;

    commit_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opnd0_w(opnd0_w), .opnd1_w(opnd1_w), .o_eflags(o_eflags), .next_eip(next_eip),
        .dest0_kind(dest0_kind), .dest1_kind(dest1_kind),
        .dest0_sel(dest0_sel), .dest1_sel(dest1_sel),
        .dest0_width(dest0_width), .dest1_width(dest1_width),
        .gprs(gprs), .eflags_q(eflags_q), .eip_q(eip_q), .commit_done(commit_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  k0; logic [2:0] s0; logic [1:0] w0; logic [31:0] d0;
        logic [1:0]  k1; logic [2:0] s1; logic [1:0] w1; logic [31:0] d1;
        logic [31:0] eip, efl;
        int          pidx;
        logic [31:0] pval, xefl;
    } vec_t;

    typedef struct {
        logic [7:0][31:0] g;
        logic [31:0]      eip, efl;
    } exp_t;

    int               checks = 0;
    int               passed = 0;
    exp_t             sbq[$];
    logic [7:0][31:0] m;
    logic             prev_done = 1'b0;
    vec_t             tbl[11];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic mwrite(input logic [1:0] k, input logic [2:0] s, input logic [1:0] w, input logic [31:0] d);
        if (k == 2'b01) begin
            case (w)
                2'b00: if (s < 3'd4) m[s][7:0] = d[7:0];
                       else          m[s[1:0]][15:8] = d[7:0];
                2'b01: m[s][15:0] = d[15:0];
                default: m[s] = d;
            endcase
        end
    endtask

    // Apply the currently driven inputs to the model and queue the expected end state.
    task automatic model_push();
        exp_t e;
        mwrite(dest0_kind, dest0_sel, dest0_width, opnd0_w);
        mwrite(dest1_kind, dest1_sel, dest1_width, opnd1_w);
        e.g   = m;
        e.eip = next_eip;
        e.efl = o_eflags;
        e.efl[1] = 1'b1;
        e.efl[3] = 1'b0;
        e.efl[5] = 1'b0;
        e.efl[15] = 1'b0;
        sbq.push_back(e);
    endtask

    task automatic drive(input vec_t v);
        dest0_kind = v.k0; dest0_sel = v.s0; dest0_width = v.w0; opnd0_w = v.d0;
        dest1_kind = v.k1; dest1_sel = v.s1; dest1_width = v.w1; opnd1_w = v.d1;
        next_eip = v.eip; o_eflags = v.efl;
    endtask

    task automatic scramble();
        dest0_kind = 2'($urandom); dest0_sel = 3'($urandom); dest0_width = 2'($urandom); opnd0_w = $urandom;
        dest1_kind = 2'($urandom); dest1_sel = 3'($urandom); dest1_width = 2'($urandom); opnd1_w = $urandom;
        next_eip = $urandom; o_eflags = $urandom;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 12 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            chk({name, "_timeout"}, 256'(sbq.size()), 256'd0);
            sbq.delete();
        end
    endtask

    function automatic vec_t mk(input logic [1:0] k0, input logic [2:0] s0, input logic [1:0] w0, input logic [31:0] d0,
                                input logic [1:0] k1, input logic [2:0] s1, input logic [1:0] w1, input logic [31:0] d1,
                                input logic [31:0] eip, input logic [31:0] efl, input int pidx,
                                input logic [31:0] pval, input logic [31:0] xefl);
        vec_t v;
        v.k0 = k0; v.s0 = s0; v.w0 = w0; v.d0 = d0;
        v.k1 = k1; v.s1 = s1; v.w1 = w1; v.d1 = d1;
        v.eip = eip; v.efl = efl; v.pidx = pidx; v.pval = pval; v.xefl = xefl;
        return v;
    endfunction

    // Scoreboard: every commit_done pulse retires the oldest expected state.
    always @(negedge clk) begin
        if (commit_done) begin
            chk("done_single_cycle", 256'(prev_done), 256'd0);
            if (sbq.size() == 0) begin
                chk("unexpected_done", 256'd1, 256'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_gprs", gprs, e.g);
                chk("sb_eip", 256'(eip_q), 256'(e.eip));
                chk("sb_eflags", 256'(eflags_q), 256'(e.efl));
            end
        end
        prev_done = commit_done;
    end

    initial begin
        tbl[0]  = mk(2'b01, 3'd0, 2'b10, 32'h1122_3344, 2'b00, 3'd0, 2'b00, 32'h0,
                     32'h1010, 32'hFFFF_FFFF, 0, 32'h1122_3344, 32'hFFFF_7FD7);
        tbl[1]  = mk(2'b01, 3'd4, 2'b00, 32'h0000_00AB, 2'b00, 3'd0, 2'b00, 32'h0,
                     32'h1014, 32'h0, 0, 32'h1122_AB44, 32'h2);
        tbl[2]  = mk(2'b01, 3'd0, 2'b01, 32'hFFFF_0001, 2'b00, 3'd0, 2'b00, 32'h0,
                     32'h1018, 32'h0, 0, 32'h1122_0001, 32'h2);
        tbl[3]  = mk(2'b01, 3'd1, 2'b10, 32'h5, 2'b01, 3'd1, 2'b10, 32'h9,
                     32'h101C, 32'h0, 1, 32'h9, 32'h2);
        tbl[4]  = mk(2'b01, 3'd3, 2'b11, 32'hAAAA_AAAA, 2'b01, 3'd3, 2'b00, 32'h55,
                     32'h1020, 32'h0, 3, 32'hAAAA_AA55, 32'h2);
        tbl[5]  = mk(2'b01, 3'd7, 2'b00, 32'h12, 2'b01, 3'd3, 2'b00, 32'h34,
                     32'h1024, 32'h0, 3, 32'hAAAA_1234, 32'h2);
        tbl[6]  = mk(2'b01, 3'd3, 2'b01, 32'h5678, 2'b01, 3'd7, 2'b00, 32'h9A,
                     32'h1028, 32'h0, 3, 32'hAAAA_9A78, 32'h2);
        tbl[7]  = mk(2'b10, 3'd6, 2'b10, 32'hFFFF_FFFF, 2'b11, 3'd6, 2'b10, 32'hFFFF_FFFF,
                     32'h102C, 32'h0, 6, 32'h0, 32'h2);
        tbl[8]  = mk(2'b01, 3'd5, 2'b01, 32'h1234_BEEF, 2'b01, 3'd5, 2'b00, 32'h77,
                     32'h1030, 32'h0, 1, 32'h0000_7709, 32'h2);
        tbl[9]  = mk(2'b00, 3'd2, 2'b10, 32'h0, 2'b01, 3'd7, 2'b10, 32'hCAFE_F00D,
                     32'h1034, 32'h0000_8028, 7, 32'hCAFE_F00D, 32'h2);
        tbl[10] = mk(2'b01, 3'd4, 2'b10, 32'h0000_FFF0, 2'b00, 3'd0, 2'b00, 32'h0,
                     32'h1038, 32'h0000_0020, 4, 32'h0000_FFF0, 32'h2);

        rst = 1'b1;
        in_valid = 1'b0;
        scramble();
        m = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_gprs", gprs, m);
        chk("rst_eip", 256'(eip_q), 256'h0);
        chk("rst_eflags", 256'(eflags_q), 256'h2);
        chk("rst_in_ready", 256'(in_ready), 256'd1);
        chk("rst_done", 256'(commit_done), 256'd0);

        // Latency sequence: EDX written after T+1, EIP/EFLAGS after T+2.
        @(negedge clk);
        drive(mk(2'b01, 3'd2, 2'b10, 32'hDEAD_BEEF, 2'b00, 3'd0, 2'b00, 32'h0,
                 32'h1005, 32'h0, 2, 32'hDEAD_BEEF, 32'h2));
        in_valid = 1'b1;
        model_push();
        @(posedge clk);
        #1 in_valid = 1'b0;
        scramble();
        @(negedge clk);
        chk("lat_wr0_ready", 256'(in_ready), 256'd0);
        chk("lat_wr0_edx", 256'(gprs[95:64]), 256'h0);
        @(negedge clk);
        chk("lat_wr1_edx", 256'(gprs[95:64]), 256'hDEAD_BEEF);
        chk("lat_wr1_eip", 256'(eip_q), 256'h0);
        chk("lat_wr1_ready", 256'(in_ready), 256'd0);
        @(negedge clk);
        chk("lat_done_hi", 256'(commit_done), 256'd1);
        chk("lat_eip", 256'(eip_q), 256'h1005);
        chk("lat_eflags", 256'(eflags_q), 256'h2);
        @(negedge clk);
        chk("lat_done_lo", 256'(commit_done), 256'd0);
        drain("lat");

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            in_valid = 1'b1;
            model_push();
            @(posedge clk);
            #1 in_valid = 1'b0;
            scramble();
            drain($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_probe", i), 256'(gprs[tbl[i].pidx*32 +: 32]), 256'(tbl[i].pval));
            chk($sformatf("vec%0d_eip", i), 256'(eip_q), 256'(tbl[i].eip));
            chk($sformatf("vec%0d_eflags", i), 256'(eflags_q), 256'(tbl[i].xefl));
        end

        // Back-to-back: in_valid held high with new data every cycle.
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            scramble();
            in_valid = 1'b1;
            chk($sformatf("b2b_ready%0d", k), 256'(in_ready), 256'((k % 3) == 0));
            if (in_ready) model_push();
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain("b2b");

        // Reset during WR1 with in_valid asserted: everything returns to reset values.
        @(negedge clk);
        drive(mk(2'b01, 3'd0, 2'b10, 32'h1234_5678, 2'b01, 3'd1, 2'b10, 32'h9ABC,
                 32'h2000, 32'hFFFF, 0, 32'h0, 32'h2));
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_wr0_applied", 256'(gprs[31:0]), 256'h1234_5678);
        rst = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        m = '0;
        chk("abort_gprs", gprs, m);
        chk("abort_eip", 256'(eip_q), 256'h0);
        chk("abort_eflags", 256'(eflags_q), 256'h2);
        chk("abort_done", 256'(commit_done), 256'd0);
        chk("abort_ready", 256'(in_ready), 256'd1);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_done_after", 256'(commit_done), 256'd0);
        chk("abort_ready_after", 256'(in_ready), 256'd1);
        chk("abort_gprs_after", gprs, m);
        repeat (3) @(negedge clk);
        chk("sb_empty", 256'(sbq.size()), 256'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 SHALL have parameter RESET_EIP, default 32'h0000_0000, EIP value after reset.
REQ-002 SHALL have parameter RESET_ESP, default 32'h0000_0000, ESP (GPR 4) value after reset.
REQ-003 SHALL have parameter RESET_EFLAGS, default 32'h0000_0002, EFLAGS value after reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  execute-stage result is presented.
REQ-007 in_ready  output  1  unit can accept a result.
REQ-008 opnd0_w, opnd1_w  input  32 each  write-operand values from execute.
REQ-009 o_eflags, next_eip  input  32 each  prospective EFLAGS and EIP from execute.
REQ-010 dest0_kind, dest1_kind  input  2 each  00 none, 01 GPR, 1x reserved.
REQ-011 dest0_sel, dest1_sel  input  3 each  GPR index (0 EAX, 1 ECX, 2 EDX, 3 EBX, 4 ESP, 5 EBP, 6 ESI, 7 EDI).
REQ-012 dest0_width, dest1_width  input  2 each  00 8-bit, 01 16-bit, 10 and 11 32-bit.
REQ-013 gprs  output  256  architectural GPRs; GPR n at bits [32n+31:32n].
REQ-014 eflags_q, eip_q  output  32 each  architectural EFLAGS and EIP.
REQ-015 commit_done  output  1  single-cycle pulse marking a completed commit.

Function
REQ-016 SHALL implement FSM states IDLE, WR0, WR1, with a single GPR write port used once per WR state.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 IDLE with in_valid=1: SHALL latch all inputs into holding registers and go to WR0; in_valid=0 stays IDLE.
REQ-019 Inputs SHALL be sampled only at acceptance; later input changes SHALL have no effect on an in-flight commit.
REQ-020 WR0: SHALL apply the dest0 write if dest0_kind=01, then go to WR1.
REQ-021 WR1: SHALL apply the dest1 write if dest1_kind=01, load eip_q from latched next_eip and eflags_q from latched o_eflags, then go to IDLE.
REQ-022 eflags_q bit 1 SHALL be forced to 1, and bits 3, 5 and 15 forced to 0, on every load.
REQ-023 commit_done SHALL be registered, 1 for exactly the cycle after WR1, otherwise 0.
REQ-024 Latency SHALL be: accept at edge T, dest0 visible after T+1, dest1/EIP/EFLAGS visible after T+2, commit_done high in cycle T+2..T+3.
REQ-025 A new result MAY be accepted in the cycle commit_done is high (back-to-back); peak throughput SHALL be one commit per 3 cycles.
REQ-026 A 32-bit write SHALL replace the entire selected GPR.
REQ-027 A 16-bit write SHALL replace bits [15:0] of GPR sel and preserve bits [31:16].
REQ-028 An 8-bit write with sel 0-3 SHALL replace bits [7:0] of GPR sel.
REQ-029 An 8-bit write with sel 4-7 SHALL replace bits [15:8] of GPR sel-4 (AH/CH/DH/BH).
REQ-030 All other bits of an 8-bit write SHALL be preserved.
REQ-031 Write data SHALL be the low 8/16/32 bits of the operand.
REQ-032 dest_kind 1x or 00 SHALL write nothing in that WR state.
REQ-033 If dest0 and dest1 target the same GPR bits, the dest1 value SHALL win, since it is written later; partially overlapping widths SHALL merge in that order.
REQ-034 GPRs not addressed by a commit SHALL be unchanged.

Reset
REQ-035 When rst=1 at a clock edge, the FSM SHALL go to IDLE.
REQ-036 rst=1 at a clock edge SHALL load gprs to 0 except ESP, which SHALL load RESET_ESP.
REQ-037 rst=1 at a clock edge SHALL load eip_q=RESET_EIP and eflags_q=RESET_EFLAGS|32'h2.
REQ-038 rst=1 at a clock edge SHALL clear commit_done and the holding registers.
REQ-039 rst SHALL take priority over all activity.
REQ-040 rst asserted in WR0 or WR1 SHALL abort the commit with no partial GPR, EIP or EFLAGS update surviving.
REQ-041 in_valid SHALL be ignored while rst=1.

Verification
REQ-042 Reset, default params: gprs=0, eip_q=0, eflags_q=32'h2, in_ready=1, commit_done=0.
REQ-043 Accept dest0 GPR2/32-bit 32'hDEADBEEF, dest1 none, next_eip=32'h1005, o_eflags=32'h0 -> EDX=DEADBEEF after T+1, eip_q=1005 and eflags_q=2 after T+2, commit_done pulse one cycle.
REQ-044 EAX=32'h11223344; dest0 sel 4 width 8-bit data 32'hAB -> EAX=112233AB? No: AH -> EAX=1122AB44; a following 16-bit write 32'hFFFF0001 to sel 0 -> EAX=11220001.
REQ-045 XCHG-style commit, dest0 GPR1=5 and dest1 GPR1=9, both 32-bit -> ECX=9 after commit.
REQ-046 Hold in_valid=1 continuously with changing data -> accepts exactly every third cycle, in_ready low in WR0/WR1, each commit matches data sampled at its acceptance.
REQ-047 rst pulsed during WR1 -> no write of dest1/EIP/EFLAGS, all outputs equal reset values next cycle, commit_done stays 0.
